// File: rtl/matvec_engine.sv
// Matrix-vector engine: polls the MMIO flag, reads A/X/C bases and M/N, computes C = A*X.
// Optional per-row bias initialisation is enabled by defining MATVEC_BIAS_EN.
module matvec_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic                         mem_we,
    input  logic signed [DATA_WIDTH-1:0] mem_rdata,
    output logic                         busy,
    output logic                         done
);

    localparam logic [ADDR_WIDTH-1:0] AddrABase = ADDR_WIDTH'(32'h300);
    localparam logic [ADDR_WIDTH-1:0] AddrXBase = ADDR_WIDTH'(32'h400);
    localparam logic [ADDR_WIDTH-1:0] AddrCBase = ADDR_WIDTH'(32'h500);
    localparam logic [ADDR_WIDTH-1:0] AddrM     = ADDR_WIDTH'(32'h600);
    localparam logic [ADDR_WIDTH-1:0] AddrN     = ADDR_WIDTH'(32'h700);
    localparam logic [ADDR_WIDTH-1:0] AddrFlag  = ADDR_WIDTH'(32'hB00);
`ifdef MATVEC_BIAS_EN
    localparam logic [ADDR_WIDTH-1:0] AddrBias  = ADDR_WIDTH'(32'hD00);
    localparam logic [2:0]            CfgEnd    = 3'd7;
`else
    localparam logic [2:0]            CfgEnd    = 3'd6;
`endif

    typedef enum logic [2:0] {
        StIdle, StCfg, StFetchA, StFetchX, StMac, StWriteC, StFlag, StBias
    } state_e;

    state_e                        state_q, state_d;
    logic                          phase_q, phase_d;
    logic [2:0]                    cfg_cnt_q, cfg_cnt_d;
    logic [ADDR_WIDTH-1:0]         a_base_q, a_base_d;
    logic [ADDR_WIDTH-1:0]         x_base_q, x_base_d;
    logic [ADDR_WIDTH-1:0]         c_base_q, c_base_d;
    logic [DATA_WIDTH-1:0]         m_q, m_d;
    logic [DATA_WIDTH-1:0]         n_q, n_d;
    logic [DATA_WIDTH-1:0]         i_q, i_d;
    logic [DATA_WIDTH-1:0]         j_q, j_d;
    logic signed [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]  a_q, a_d;
    logic [ADDR_WIDTH-1:0]         row_ptr_q, row_ptr_d;
    logic [1:0]                    status_q, status_d;
`ifdef MATVEC_BIAS_EN
    logic [ADDR_WIDTH-1:0]         bias_base_q, bias_base_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            phase_q     <= 1'b0;
            cfg_cnt_q   <= '0;
            a_base_q    <= '0;
            x_base_q    <= '0;
            c_base_q    <= '0;
            m_q         <= '0;
            n_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            row_ptr_q   <= '0;
            status_q    <= '0;
`ifdef MATVEC_BIAS_EN
            bias_base_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cfg_cnt_q   <= cfg_cnt_d;
            a_base_q    <= a_base_d;
            x_base_q    <= x_base_d;
            c_base_q    <= c_base_d;
            m_q         <= m_d;
            n_q         <= n_d;
            i_q         <= i_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            a_q         <= a_d;
            row_ptr_q   <= row_ptr_d;
            status_q    <= status_d;
`ifdef MATVEC_BIAS_EN
            bias_base_q <= bias_base_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cfg_cnt_d   = cfg_cnt_q;
        a_base_d    = a_base_q;
        x_base_d    = x_base_q;
        c_base_d    = c_base_q;
        m_d         = m_q;
        n_d         = n_q;
        i_d         = i_q;
        j_d         = j_q;
        acc_d       = acc_q;
        a_d         = a_q;
        row_ptr_d   = row_ptr_q;
        status_d    = status_q;
`ifdef MATVEC_BIAS_EN
        bias_base_d = bias_base_q;
`endif
        mem_addr    = AddrFlag;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        done        = 1'b0;

        case (state_q)
            StIdle: begin
                // Flag is read on phase 0 and its data checked on phase 1.
                phase_d = ~phase_q;
                if (phase_q && mem_rdata == DATA_WIDTH'(1)) begin
                    state_d   = StCfg;
                    phase_d   = 1'b0;
                    cfg_cnt_d = '0;
                end
            end
            StCfg: begin
                // Address k is presented at count k; its data is latched at count k+1.
                case (cfg_cnt_q)
                    3'd0: mem_addr = AddrABase;
                    3'd1: mem_addr = AddrXBase;
                    3'd2: mem_addr = AddrCBase;
                    3'd3: mem_addr = AddrM;
                    3'd4: mem_addr = AddrN;
`ifdef MATVEC_BIAS_EN
                    3'd5: mem_addr = AddrBias;
`endif
                    default: mem_addr = AddrFlag;
                endcase
                case (cfg_cnt_q)
                    3'd1: a_base_d = mem_rdata[ADDR_WIDTH-1:0];
                    3'd2: x_base_d = mem_rdata[ADDR_WIDTH-1:0];
                    3'd3: c_base_d = mem_rdata[ADDR_WIDTH-1:0];
                    3'd4: m_d      = mem_rdata;
                    3'd5: n_d      = mem_rdata;
`ifdef MATVEC_BIAS_EN
                    3'd6: bias_base_d = mem_rdata[ADDR_WIDTH-1:0];
`endif
                    default: ;
                endcase
                cfg_cnt_d = cfg_cnt_q + 3'd1;
                if (cfg_cnt_q == CfgEnd) begin
                    if (m_q == '0 || n_q == '0) begin
                        status_d = 2'd3;
                        state_d  = StFlag;
                    end else begin
                        i_d       = '0;
                        j_d       = '0;
                        acc_d     = '0;
                        row_ptr_d = a_base_q;
`ifdef MATVEC_BIAS_EN
                        state_d   = StBias;
`else
                        state_d   = StFetchA;
`endif
                    end
                end
            end
`ifdef MATVEC_BIAS_EN
            StBias: begin
                mem_addr = bias_base_q + ADDR_WIDTH'(i_q);
                state_d  = StFetchA;
            end
`endif
            StFetchA: begin
                mem_addr = row_ptr_q + ADDR_WIDTH'(j_q);
`ifdef MATVEC_BIAS_EN
                // The bias word requested in StBias arrives on the row's first fetch.
                if (j_q == '0) begin
                    acc_d = mem_rdata;
                end
`endif
                state_d  = StFetchX;
            end
            StFetchX: begin
                mem_addr = x_base_q + ADDR_WIDTH'(j_q);
                a_d      = mem_rdata;
                state_d  = StMac;
            end
            StMac: begin
                acc_d = acc_q + a_q * mem_rdata;
                if (j_q == n_q - DATA_WIDTH'(1)) begin
                    state_d = StWriteC;
                end else begin
                    j_d     = j_q + DATA_WIDTH'(1);
                    state_d = StFetchA;
                end
            end
            StWriteC: begin
                mem_we    = 1'b1;
                mem_addr  = c_base_q + ADDR_WIDTH'(i_q);
                mem_wdata = acc_q;
                if (i_q == m_q - DATA_WIDTH'(1)) begin
                    status_d = 2'd2;
                    state_d  = StFlag;
                end else begin
                    i_d       = i_q + DATA_WIDTH'(1);
                    j_d       = '0;
                    acc_d     = '0;
                    row_ptr_d = row_ptr_q + ADDR_WIDTH'(n_q);
`ifdef MATVEC_BIAS_EN
                    state_d   = StBias;
`else
                    state_d   = StFetchA;
`endif
                end
            end
            StFlag: begin
                mem_we    = 1'b1;
                mem_addr  = AddrFlag;
                mem_wdata = DATA_WIDTH'(status_q);
                done      = 1'b1;
                phase_d   = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_matvec_engine.sv
// Directed bench for matvec_engine with a one-cycle-latency memory model on port B.
module tb_matvec_engine;

    localparam int DW = 32;
    localparam int AW = 16;
`ifdef MATVEC_BIAS_EN
    localparam bit BIAS_ON = 1'b1;
`else
    localparam bit BIAS_ON = 1'b0;
`endif
    localparam logic [DW-1:0] SENT = 32'hDEAD_BEEF;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_we;
    logic signed [DW-1:0] mem_rdata;
    logic                 busy;
    logic                 done;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int d00_cnt = 0;
    int other_addr_cnt = 0;
    int busy_cnt = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    matvec_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    always @(posedge clk) begin
        if (mem_we) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (mem_addr == 16'hD00) d00_cnt <= d00_cnt + 1;
        if (mem_addr != 16'hB00) other_addr_cnt <= other_addr_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [DW-1:0] v);
        mem[a] <= v;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, DW'(done_cnt != start), 32'd1);
    endtask

    task automatic load_base(input int m, input int n);
        poke(16'h300, 32'h1000);
        poke(16'h400, 32'h1100);
        poke(16'h500, 32'h1200);
        poke(16'h600, m);
        poke(16'h700, n);
        poke(16'hD00, 32'h1300);
        poke(16'h1200, SENT);
        poke(16'h1201, SENT);
    endtask

    task automatic load_27();
        load_base(2, 3);
        poke(16'h1000, 1); poke(16'h1001, 2); poke(16'h1002, 3);
        poke(16'h1003, 4); poke(16'h1004, 5); poke(16'h1005, 6);
        poke(16'h1100, 1); poke(16'h1101, 1); poke(16'h1102, 2);
        poke(16'h1300, 10); poke(16'h1301, -1);
    endtask

    initial begin
        int snap_wr, snap_done, snap_d00, snap_oth, snap_busy, n;
        logic [DW-1:0] exp0, exp1;

        for (int a = 0; a < (1 << AW); a++) mem[a] <= '0;
        repeat (3) @(negedge clk);
        check("rst_addr", DW'(mem_addr), 32'hB00);
        check("rst_we", DW'(mem_we), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_busy", DW'(busy), 32'd0);
        check("rst_done", DW'(done), 32'd0);
        rst_n = 1'b1;

        // Flag stays 0: only flag polling, no writes, never busy.
        snap_wr = wr_cnt; snap_oth = other_addr_cnt; snap_busy = busy_cnt;
        repeat (100) @(negedge clk);
        check("idle_addr", DW'(other_addr_cnt - snap_oth), 32'd0);
        check("idle_we", DW'(wr_cnt - snap_wr), 32'd0);
        check("idle_busy", DW'(busy_cnt - snap_busy), 32'd0);

        // 2x3 example; with bias the rows start from 10 and -1.
        exp0 = BIAS_ON ? 32'd19 : 32'd9;
        exp1 = BIAS_ON ? 32'd20 : 32'd21;
        load_27();
        @(negedge clk);
        snap_wr = wr_cnt; snap_done = done_cnt; snap_d00 = d00_cnt;
        poke(16'hB00, 1);
        wait_done("run27_done", 300);
        repeat (3) @(negedge clk);
        check("run27_c0", mem[16'h1200], exp0);
        check("run27_c1", mem[16'h1201], exp1);
        check("run27_flag", mem[16'hB00], 32'd2);
        check("run27_writes", DW'(wr_cnt - snap_wr), 32'd3);
        check("run27_done_cnt", DW'(done_cnt - snap_done), 32'd1);
        check("run27_busy", DW'(busy), 32'd0);
        check("run27_bias_rd", DW'(d00_cnt != snap_d00), DW'(BIAS_ON));

        // Signed 1x2: -3*5 + 4*-2 = -23.
        load_base(1, 2);
        poke(16'h1000, -3); poke(16'h1001, 4);
        poke(16'h1100, 5);  poke(16'h1101, -2);
        poke(16'h1300, 0);
        poke(16'hB00, 1);
        wait_done("neg_done", 300);
        repeat (3) @(negedge clk);
        check("neg_c0", mem[16'h1200], 32'hFFFF_FFE9);
        check("neg_flag", mem[16'hB00], 32'd2);

        // 0x7FFFFFFF*2 wraps to 0xFFFFFFFE.
        load_base(1, 2);
        poke(16'h1000, 32'h7FFF_FFFF); poke(16'h1001, 1);
        poke(16'h1100, 2); poke(16'h1101, 0);
        poke(16'hB00, 1);
        wait_done("wrap_done", 300);
        repeat (3) @(negedge clk);
        check("wrap_c0", mem[16'h1200], 32'hFFFF_FFFE);

        // M=0: only the status write happens.
        load_base(0, 4);
        @(negedge clk);
        snap_wr = wr_cnt; snap_done = done_cnt;
        poke(16'hB00, 1);
        wait_done("m0_done", 300);
        repeat (3) @(negedge clk);
        check("m0_c0", mem[16'h1200], SENT);
        check("m0_writes", DW'(wr_cnt - snap_wr), 32'd1);
        check("m0_flag", mem[16'hB00], 32'd3);
        check("m0_done_cnt", DW'(done_cnt - snap_done), 32'd1);

        // Reset during row 1, then rerun from the still-set flag.
        load_27();
        @(negedge clk);
        snap_wr = wr_cnt;
        poke(16'hB00, 1);
        n = 0;
        while (wr_cnt == snap_wr && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("abort_row0_written", DW'(wr_cnt != snap_wr), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", DW'(busy), 32'd0);
        check("abort_we", DW'(mem_we), 32'd0);
        check("abort_addr", DW'(mem_addr), 32'hB00);
        snap_wr = wr_cnt;
        repeat (4) @(negedge clk);
        check("abort_no_writes", DW'(wr_cnt - snap_wr), 32'd0);
        check("abort_c1", mem[16'h1201], SENT);
        check("abort_flag", mem[16'hB00], 32'd1);
        rst_n = 1'b1;
        wait_done("rerun_done", 300);
        repeat (3) @(negedge clk);
        check("rerun_c0", mem[16'h1200], exp0);
        check("rerun_c1", mem[16'h1201], exp1);
        check("rerun_flag", mem[16'hB00], 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
